column_accumulator: RTL and testbench
=====================================

Name: column_accumulator

Overview:
- Collects the result stream leaving the bottom PE of one systolic-array column into a 2-entry result store.
- Raises a full flag when a complete column result is present, and holds it until the writeback controller acknowledges the write into the unified buffer.
- Supports overwrite mode and accumulate mode (add onto held partial sums) for K-tiled matmuls.
- Two instances per 2x2 array; their full flags and mem outputs form the write side of the unified buffer.

Parameters:
- DATA_W, 32, width of PE results, stored entries and mem outputs.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  data_in carries a column result this cycle.
- data_in  input  DATA_W  result word from the bottom PE of the column.
- accumulate  input  1  sampled on the first accepted write of a fill:
  - 1: add incoming words onto current entries.
  - 0: overwrite current entries.
- store_ack  input  1  the unified buffer has consumed mem_0/mem_1 this cycle.
- clear  input  1  synchronous clear of entries, pointer and flags.
- mem_0  output  DATA_W  entry 0, registered.
- mem_1  output  DATA_W  entry 1, registered.
- full  output  1  both entries hold a complete result, registered.
- overflow  output  1  sticky: a valid_in was dropped while full.

Behaviour:
- Reset (async): mem_0=0, mem_1=0, full=0, overflow=0, wr_ptr=0, acc_mode=0, state=EMPTY.
- States:
  - EMPTY: wr_ptr=0, no fill in progress.
  - FILLING: entry 0 written, awaiting entry 1.
  - FULL: full=1, awaiting store_ack.
- EMPTY, valid_in=1:
  - acc_mode <= accumulate.
  - mem_0 <= acc_mode_new ? mem_0+data_in : data_in.
  - -> FILLING.
- FILLING, valid_in=1:
  - mem_1 written with the same rule, using the latched acc_mode.
  - -> FULL; full=1 from the next cycle (1-cycle latency from the second valid_in).
- FILLING, valid_in=0: hold. No timeout.
- FULL, store_ack=1: -> EMPTY, full=0 next cycle. Entries are retained; overwrite mode replaces them on the next fill.
- FULL, valid_in=1 and store_ack=0: word dropped, overflow<=1, entries unchanged.
- FULL, store_ack=1 and valid_in=1 in the same cycle: the ack is honoured and the word is accepted as entry 0 of the next fill (-> FILLING, full=0 next cycle).
- store_ack outside FULL: ignored, no effect.
- clear=1: highest priority after reset. Next cycle mem_0=mem_1=0, full=0, overflow=0, state=EMPTY. The same-cycle valid_in is discarded.
- Arithmetic: accumulate adds wrap modulo 2^DATA_W, unsigned/two's-complement agnostic, no saturation.
- Mid-fill reset or clear: the partial fill is lost, and the next valid_in is entry 0.
- Outputs change only on posedge clk or reset; no combinational path from inputs to outputs.

Test Plan:
- Reset then valid_in with data 5, 7, accumulate=0 -> full=1 one cycle after the 7; mem_0=5, mem_1=7, overflow=0.
- After the above, store_ack pulse, then valid_in 3, 4 with accumulate=1 -> mem_0=8, mem_1=11, full=1.
- While full, valid_in data 99 with no ack -> mem unchanged (8, 11), overflow=1 and stays set through a later ack until clear.
- In FULL, same-cycle store_ack and valid_in 42 with accumulate=0 -> next cycle full=0 and mem_0=42; a following valid_in 43 -> mem_1=43, full=1.
- Accumulate wrap: entries 32'hFFFFFFFF and 1, then accumulate 1, 1 -> mem_0=0, mem_1=2.
- Async reset asserted between the two words of a fill -> all outputs 0 immediately. After release, valid_in 6, 9 -> mem_0=6, mem_1=9, full=1.

Source files
------------

// File: rtl/column_accumulator.sv
// column_accumulator: two-entry result store for one systolic column, with overwrite/accumulate fills and a full/ack handshake
module column_accumulator #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              accumulate,
    input  logic              store_ack,
    input  logic              clear,
    output logic [DATA_W-1:0] mem_0,
    output logic [DATA_W-1:0] mem_1,
    output logic              full,
    output logic              overflow
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem_0_q, mem_0_d, mem_1_q, mem_1_d;
    logic acc_mode_q, acc_mode_d, overflow_q, overflow_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            mem_0_q    <= '0;
            mem_1_q    <= '0;
            acc_mode_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_0_q    <= mem_0_d;
            mem_1_q    <= mem_1_d;
            acc_mode_q <= acc_mode_d;
            overflow_q <= overflow_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        mem_0_d    = mem_0_q;
        mem_1_d    = mem_1_q;
        acc_mode_d = acc_mode_q;
        overflow_d = overflow_q;
        if (clear) begin
            state_d    = EMPTY;
            mem_0_d    = '0;
            mem_1_d    = '0;
            acc_mode_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (valid_in) begin
                    acc_mode_d = accumulate;
                    mem_0_d    = accumulate ? mem_0_q + data_in : data_in;
                    state_d    = FILLING;
                end
                FILLING: if (valid_in) begin
                    mem_1_d = acc_mode_q ? mem_1_q + data_in : data_in;
                    state_d = FULL;
                end
                FULL: begin
                    // an ack frees the store in the same cycle, so a coincident word starts the next fill
                    if (store_ack) begin
                        state_d = EMPTY;
                        if (valid_in) begin
                            acc_mode_d = accumulate;
                            mem_0_d    = accumulate ? mem_0_q + data_in : data_in;
                            state_d    = FILLING;
                        end
                    end else if (valid_in) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    assign mem_0    = mem_0_q;
    assign mem_1    = mem_1_q;
    assign full     = (state_q == FULL);
    assign overflow = overflow_q;
endmodule

// File: tb/tb_column_accumulator.sv
// tb_column_accumulator: directed stimulus with a scoreboard checked on each rising full flag
module tb_column_accumulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        accumulate = 1'b0;
    logic        store_ack = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] mem_0, mem_1;
    logic        full, overflow;

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        logic        ov;
    } exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    column_accumulator #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .accumulate(accumulate), .store_ack(store_ack), .clear(clear),
        .mem_0(mem_0), .mem_1(mem_1), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic acc, input logic ack, input logic clr);
        @(negedge clk);
        valid_in   = v;
        data_in    = d;
        accumulate = acc;
        store_ack  = ack;
        clear      = clr;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        store_ack = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic push(input logic [31:0] m0, input logic [31:0] m1, input logic ov);
        exp_t e;
        e.m0 = m0;
        e.m1 = m1;
        e.ov = ov;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        logic full_prev;
        exp_t e;
        full_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (full && !full_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_full: got mem_0=%h mem_1=%h with no expectation", mem_0, mem_1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_mem_0", mem_0, e.m0);
                    chk("sb_mem_1", mem_1, e.m1);
                    chk("sb_overflow", {31'b0, overflow}, {31'b0, e.ov});
                end
            end
            full_prev = full;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_mem_0", mem_0, 32'd0);
        chk("rst_mem_1", mem_1, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        reset = 1'b0;

        push(32'd5, 32'd7, 1'b0);
        step(1, 32'd5, 0, 0, 0);
        chk("fill1_not_full", {31'b0, full}, 32'd0);
        step(1, 32'd7, 0, 0, 0);
        chk("fill1_full", {31'b0, full}, 32'd1);

        step(0, 32'd0, 0, 1, 0);
        chk("ack_clears_full", {31'b0, full}, 32'd0);
        push(32'd8, 32'd11, 1'b0);
        step(1, 32'd3, 1, 0, 0);
        step(1, 32'd4, 0, 0, 0);
        chk("acc_full", {31'b0, full}, 32'd1);

        step(1, 32'd99, 0, 0, 0);
        chk("drop_mem_0", mem_0, 32'd8);
        chk("drop_mem_1", mem_1, 32'd11);
        chk("drop_overflow", {31'b0, overflow}, 32'd1);
        chk("drop_still_full", {31'b0, full}, 32'd1);
        step(0, 32'd0, 0, 1, 0);
        chk("ovf_sticky_ack", {31'b0, overflow}, 32'd1);

        push(32'd1, 32'd2, 1'b1);
        step(1, 32'd1, 0, 0, 0);
        step(1, 32'd2, 0, 0, 0);
        push(32'd42, 32'd43, 1'b1);
        step(1, 32'd42, 0, 1, 0);
        chk("ackvalid_full", {31'b0, full}, 32'd0);
        chk("ackvalid_mem_0", mem_0, 32'd42);
        step(1, 32'd43, 0, 0, 0);
        chk("ackvalid_mem_1", mem_1, 32'd43);
        chk("ackvalid_refull", {31'b0, full}, 32'd1);

        step(1, 32'd77, 0, 0, 1);
        chk("clr_mem_0", mem_0, 32'd0);
        chk("clr_mem_1", mem_1, 32'd0);
        chk("clr_full", {31'b0, full}, 32'd0);
        chk("clr_overflow", {31'b0, overflow}, 32'd0);

        push(32'hFFFF_FFFF, 32'd1, 1'b0);
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        step(1, 32'd1, 0, 0, 0);
        step(0, 32'd0, 0, 1, 0);
        push(32'd0, 32'd2, 1'b0);
        step(1, 32'd1, 1, 0, 0);
        step(1, 32'd1, 0, 0, 0);
        step(0, 32'd0, 0, 1, 0);

        step(1, 32'd123, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_0", mem_0, 32'd0);
        chk("arst_mem_1", mem_1, 32'd0);
        chk("arst_full", {31'b0, full}, 32'd0);
        chk("arst_overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push(32'd6, 32'd9, 1'b0);
        step(1, 32'd6, 0, 0, 0);
        step(0, 32'd0, 0, 1, 0);
        chk("ack_in_filling_ignored", {31'b0, full}, 32'd0);
        step(1, 32'd9, 0, 0, 0);
        chk("post_rst_mem_0", mem_0, 32'd6);
        chk("post_rst_full", {31'b0, full}, 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
